// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the request, data and grant signals shared between the requesters
// and the round-robin arbiter that owns the 4:1 select.
interface mux4_rr_arbiter_if #(
    parameter int DW = 1
);
    logic [3:0]      req;
    logic [4*DW-1:0] din;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic            busy;
    logic [DW-1:0]   dout;
    logic            valid;

    // Requester side: raises requests and presents lane data.
    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  busy,
        input  dout,
        input  valid
    );

    // Arbiter side: grants one lane at a time and forwards its data.
    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output busy,
        output dout,
        output valid
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 select datapath. Grants one requester
// at a time, caps each grant at MAX_HOLD beats when someone else is waiting,
// and registers the granted lane's data on every transfer beat.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; SEL keeps the last granted index
// GRANT | lane sel_q owns the select; beats counted in hcnt_q
module mux4_rr_arbiter #(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mux4_rr_arbiter_if.slave        bus
);

    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;

    logic [DW-1:0] lane [4];
    logic [3:0]    req_others;
    logic [1:0]    sel_inc;
    logic          beat;
    logic          hold_hit;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign lane[i] = bus.din[i*DW +: DW];
    end

    // First requesting lane found walking circularly upward from start.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // State, select, pointer, hold counter and output stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            hcnt_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    // Arbitration: grant from IDLE, release/handoff, and hold-limit rotation.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hcnt_d     = hcnt_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;

        sel_inc    = sel_q + 2'd1;
        req_others = bus.req & ~(4'b0001 << sel_q);
        beat       = (state_q == GRANT) && bus.req[sel_q];
        // Saturated counter still counts as "at the limit" so a late waiter
        // rotates at the end of the very next beat.
        hold_hit   = (hcnt_q == HOLD_MAX) || (hcnt_q == HOLD_MAX - HW'(1));

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    sel_d   = rr_pick(bus.req, ptr_q);
                    hcnt_d  = '0;
                end
            end
            GRANT: begin
                if (beat) begin
                    valid_d = 1'b1;
                    dout_d  = lane[sel_q];
                    if (hold_hit && (|req_others)) begin
                        ptr_d  = sel_inc;
                        sel_d  = rr_pick(req_others, sel_inc);
                        hcnt_d = '0;
                    end else if (hcnt_q != HOLD_MAX) begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end else begin
                    // Release wins over the hold limit: no beat, hand off directly.
                    ptr_d  = sel_inc;
                    hcnt_d = '0;
                    if (|req_others) begin
                        sel_d = rr_pick(req_others, sel_inc);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt   = (state_q == GRANT) ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.sel   = sel_q;
    assign bus.busy  = (state_q == GRANT);
    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed scenarios followed by random
// request traffic, all run against a behavioural model of the arbitration rules.
module tb_mux4_rr_arbiter;

    localparam int DW       = 8;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    mux4_rr_arbiter_if #(.DW(DW)) bus ();

    mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] sb_q[$];

    // Model: who owns the select (-1 = nobody), rotation pointer, last select,
    // beats served in the current grant, and whether the coming edge is a beat.
    int m_owner;
    int m_ptr;
    int m_sel;
    int m_served;
    bit m_beat;

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_ptr    = 0;
        m_sel    = 0;
        m_served = 0;
        m_beat   = 0;
        sb_q.delete();
    endtask

    // Present inputs for the next edge and advance the model across that edge.
    task automatic drive(input logic [3:0] r, input logic [4*DW-1:0] d);
        logic [3:0] others;
        bus.req = r;
        bus.din = d;
        m_beat  = 0;
        if (m_owner < 0) begin
            if (r != 4'b0000) begin
                m_owner  = first_from(r, m_ptr);
                m_sel    = m_owner;
                m_served = 0;
            end
        end else if (!r[m_owner]) begin
            m_ptr    = (m_owner + 1) % 4;
            m_served = 0;
            if (r != 4'b0000) begin
                m_owner = first_from(r, m_ptr);
                m_sel   = m_owner;
            end else begin
                m_owner = -1;
            end
        end else begin
            m_beat = 1;
            sb_q.push_back(d[m_owner*DW +: DW]);
            if (m_served < MAX_HOLD) m_served++;
            others          = r;
            others[m_owner] = 1'b0;
            if (m_served == MAX_HOLD && others != 4'b0000) begin
                m_ptr    = (m_owner + 1) % 4;
                m_owner  = first_from(others, m_ptr);
                m_sel    = m_owner;
                m_served = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("gnt",   bus.gnt,   (m_owner < 0) ? 0 : (1 << m_owner));
        check("sel",   bus.sel,   m_sel);
        check("busy",  bus.busy,  (m_owner >= 0));
        check("valid", bus.valid, m_beat);
    endtask

    task automatic cyc(input logic [3:0] r, input logic [4*DW-1:0] d);
        drive(r, d);
        tick();
    endtask

    // Monitor: every VALID beat must match the oldest expected beat.
    initial begin
        logic [DW-1:0] exp_d;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.valid === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_extra: got beat data %0h expected no beat at %0t", bus.dout, $time);
                end else begin
                    exp_d = sb_q.pop_front();
                    if (bus.dout !== exp_d) begin
                        failures++;
                        $display("FAIL sb_data: got %0h expected %0h at %0t", bus.dout, exp_d, $time);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]      rq;
        logic [4*DW-1:0] dd;
        logic [DW-1:0]   burst_vals [3];
        burst_vals[0] = 8'h11;
        burst_vals[1] = 8'h22;
        burst_vals[2] = 8'h33;

        model_reset();
        bus.req = 4'b1111;
        bus.din = '0;

        // Reset takes effect with no clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("rst_gnt",   bus.gnt,   4'b0000);
        check("rst_sel",   bus.sel,   2'b00);
        check("rst_busy",  bus.busy,  1'b0);
        check("rst_valid", bus.valid, 1'b0);
        check("rst_out",   bus.dout,  8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness: all four request continuously.
        for (int t = 0; t < 20; t++) begin
            cyc(4'b1111, $urandom);
            check("fair_lane", bus.gnt, 1 << ((t / 4) % 4));
            if (t > 0) check("fair_valid", bus.valid, 1'b1);
        end
        cyc(4'b0000, '0);

        // Single burst on lane 2, then a 1001 request must go to lane 3.
        cyc(4'b0100, '0);
        check("burst_gnt", bus.gnt, 4'b0100);
        check("burst_sel", bus.sel, 2'b10);
        for (int k = 0; k < 3; k++) begin
            dd = $urandom;
            dd[2*DW +: DW] = burst_vals[k];
            cyc(4'b0100, dd);
            check("burst_out", bus.dout, burst_vals[k]);
        end
        cyc(4'b0000, '0);
        check("burst_idle", bus.busy, 1'b0);
        cyc(4'b1001, $urandom);
        check("burst_ptr", bus.gnt, 4'b1000);
        cyc(4'b0000, '0);

        // Uncontended overrun: lane 1 alone keeps the grant past MAX_HOLD.
        cyc(4'b0010, '0);
        for (int k = 0; k < 10; k++) begin
            cyc(4'b0010, $urandom);
            check("solo_gnt", bus.gnt, 4'b0010);
        end
        cyc(4'b0000, '0);

        // Late waiter while saturated: rotation at the end of the next beat.
        cyc(4'b0010, '0);
        for (int k = 0; k < 7; k++) cyc(4'b0010, $urandom);
        check("late_keep", bus.gnt, 4'b0010);
        cyc(4'b1010, $urandom);
        check("late_rot", bus.gnt, 4'b1000);
        cyc(4'b0000, '0);

        // Release handoff 0 -> 1 with no idle cycle.
        cyc(4'b0001, '0);
        cyc(4'b0011, $urandom);
        cyc(4'b0010, $urandom);
        check("handoff_gnt",  bus.gnt,  4'b0010);
        check("handoff_busy", bus.busy, 1'b1);
        cyc(4'b0000, '0);

        // Random traffic with sticky requests.
        rq = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
            end
            cyc(rq, $urandom);
        end
        cyc(4'b0000, '0);

        // Asynchronous reset in the middle of a lane-2 burst.
        cyc(4'b0100, '0);
        check("mid_gnt", bus.gnt, 4'b0100);
        cyc(4'b0100, $urandom);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_gnt",   bus.gnt,   4'b0000);
        check("mid_rst_sel",   bus.sel,   2'b00);
        check("mid_rst_busy",  bus.busy,  1'b0);
        check("mid_rst_valid", bus.valid, 1'b0);
        check("mid_rst_out",   bus.dout,  8'h00);
        bus.req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b0110, $urandom);
        check("post_rst_gnt", bus.gnt, 4'b0010);
        cyc(4'b0110, $urandom);
        cyc(4'b0000, '0);
        cyc(4'b0000, '0);

        @(negedge clk);
        #1;
        check("sb_drain", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
